// File: rtl/bch_syndrome_calc_if.sv
`default_nettype none
// ============================================================================
//  Module      : bch_syndrome_calc_if
//  Description : Bit-serial codeword input and syndrome output bundle for the
//                GF(2^13) BCH syndrome generator.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bch_syndrome_calc_if #(
    parameter int T = 4
) ();
    localparam int C_IDX_W = $clog2(2 * T) + 1;

    // Codeword input side
    logic               din;
    logic               in_valid;
    logic               in_first;
    logic               in_ready;

    // Syndrome output side
    logic [12:0]        synd_out;
    logic [C_IDX_W-1:0] synd_idx;
    logic               synd_valid;
    logic               synd_start;
    logic               synd_last;
    logic               err_free;

    // Source of codeword bits and sink of syndromes
    modport master (
        output din, in_valid, in_first,
        input  in_ready, synd_out, synd_idx, synd_valid,
        input  synd_start, synd_last, err_free
    );

    // The syndrome generator itself
    modport slave (
        input  din, in_valid, in_first,
        output in_ready, synd_out, synd_idx, synd_valid,
        output synd_start, synd_last, err_free
    );
endinterface
`default_nettype wire

// File: rtl/bch_syndrome_calc.sv
`default_nettype none
// ============================================================================
//  Module      : bch_syndrome_calc
//  Description : Serial Horner-style syndrome generator for a GF(2^13) BCH
//                decoder. Accepts one codeword bit per accepted cycle (highest
//                degree first), then streams S_1..S_2T one per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module bch_syndrome_calc #(
    parameter int          N         = 8191,
    parameter int          T         = 4,
    parameter logic [13:0] PRIM_POLY = 14'h201B
) (
    input  logic                 clk,
    input  logic                 reset,
    bch_syndrome_calc_if.slave   bus
);

    localparam int C_SW     = 13;
    localparam int C_NS     = 2 * T;
    localparam int C_IDX_W  = $clog2(C_NS) + 1;
    localparam int C_DCNT_W = (C_NS > 1) ? $clog2(C_NS) : 1;

    localparam logic [12:0]         C_N_LAST = 13'(N);
    localparam logic [C_DCNT_W-1:0] C_D_LAST = C_DCNT_W'(C_NS - 1);

    localparam logic [1:0] C_IDLE  = 2'd0;
    localparam logic [1:0] C_ACCUM = 2'd1;
    localparam logic [1:0] C_DUMP  = 2'd2;

    // ------------------------------------------------------------------------
    // Constant-multiplier construction.
    // Column k of the matrix for alpha^j is alpha^(k+j) reduced by PRIM_POLY,
    // so multiplying x by alpha^j is the XOR of the columns selected by the
    // set bits of x. Everything here folds to constants at elaboration.
    // ------------------------------------------------------------------------
    function automatic logic [C_SW*C_SW-1:0] alpha_pow_matrix(input int j);
        logic [13:0]           col;
        logic [C_SW*C_SW-1:0]  m;
        m = '0;
        for (int k = 0; k < C_SW; k++) begin
            col = 14'(1) << k;
            for (int s = 0; s < j; s++) begin
                col = col << 1;
                if (col[13]) begin
                    col = col ^ PRIM_POLY;
                end
            end
            m[k*C_SW +: C_SW] = col[C_SW-1:0];
        end
        return m;
    endfunction

    function automatic logic [C_SW-1:0] mat_mul(
        input logic [C_SW*C_SW-1:0] m,
        input logic [C_SW-1:0]      x
    );
        logic [C_SW-1:0] p;
        p = '0;
        for (int k = 0; k < C_SW; k++) begin
            if (x[k]) begin
                p = p ^ m[k*C_SW +: C_SW];
            end
        end
        return p;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]                  state_q, state_d;
    logic [12:0]                 cnt_q, cnt_d;
    logic [C_DCNT_W-1:0]         dcnt_q, dcnt_d;
    logic [C_NS-1:0][C_SW-1:0]   synd_q, synd_d;

    logic [C_SW-1:0]             out_q, out_d;
    logic [C_IDX_W-1:0]          idx_q, idx_d;
    logic                        valid_q, valid_d;
    logic                        start_q, start_d;
    logic                        last_q, last_d;
    logic                        ef_q, ef_d;

    logic [C_NS-1:0][C_SW-1:0]   w_mul;
    logic [C_SW-1:0]             w_din_ext;
    logic                        w_ready;
    logic                        w_accept;
    logic                        w_all_zero;

    // One constant alpha^j multiplier per syndrome accumulator (j = g+1)
    generate
        for (genvar g = 0; g < C_NS; g++) begin : g_mul
            localparam logic [C_SW*C_SW-1:0] C_MAT = alpha_pow_matrix(g + 1);
            assign w_mul[g] = mat_mul(C_MAT, synd_q[g]);
        end
    endgenerate

    assign w_din_ext = {{(C_SW-1){1'b0}}, bus.din};
    assign w_ready   = (state_q != C_DUMP);
    assign w_accept  = bus.in_valid && w_ready;

    // Error-free flag source: every accumulator is zero
    always_comb begin
        w_all_zero = 1'b1;
        for (int g = 0; g < C_NS; g++) begin
            if (synd_q[g] != '0) begin
                w_all_zero = 1'b0;
            end
        end
    end

    // Next-state logic: frame capture, Horner accumulation and syndrome dump
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dcnt_d  = dcnt_q;
        synd_d  = synd_q;
        out_d   = out_q;
        idx_d   = idx_q;
        valid_d = 1'b0;
        start_d = 1'b0;
        last_d  = 1'b0;
        ef_d    = ef_q;

        case (state_q)
            C_IDLE: begin
                // Only a frame start is of interest; stray bits are dropped
                if (w_accept && bus.in_first) begin
                    for (int g = 0; g < C_NS; g++) begin
                        synd_d[g] = w_din_ext;
                    end
                    cnt_d   = 13'd1;
                    state_d = C_ACCUM;
                end
            end

            C_ACCUM: begin
                if (w_accept) begin
                    if (bus.in_first) begin
                        // A new frame start throws away the partial frame
                        for (int g = 0; g < C_NS; g++) begin
                            synd_d[g] = w_din_ext;
                        end
                        cnt_d = 13'd1;
                    end else begin
                        for (int g = 0; g < C_NS; g++) begin
                            synd_d[g] = w_mul[g] ^ w_din_ext;
                        end
                        cnt_d = cnt_q + 13'd1;
                        if (cnt_d == C_N_LAST) begin
                            dcnt_d  = '0;
                            state_d = C_DUMP;
                        end
                    end
                end
            end

            C_DUMP: begin
                // Accumulators are frozen here; present one syndrome per cycle
                valid_d = 1'b1;
                out_d   = synd_q[dcnt_q];
                idx_d   = C_IDX_W'(dcnt_q) + C_IDX_W'(1);
                start_d = (dcnt_q == '0);
                if (dcnt_q == C_D_LAST) begin
                    last_d  = 1'b1;
                    ef_d    = w_all_zero;
                    state_d = C_IDLE;
                end else begin
                    dcnt_d = dcnt_q + C_DCNT_W'(1);
                end
            end

            default: begin
                state_d = C_IDLE;
            end
        endcase
    end

    // State and registered-output update with asynchronous active-low clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= C_IDLE;
            cnt_q   <= '0;
            dcnt_q  <= '0;
            synd_q  <= '0;
            out_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            last_q  <= 1'b0;
            ef_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dcnt_q  <= dcnt_d;
            synd_q  <= synd_d;
            out_q   <= out_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            start_q <= start_d;
            last_q  <= last_d;
            ef_q    <= ef_d;
        end
    end

    // in_ready is gated by reset so that every output reads 0 while it is held
    assign bus.in_ready   = reset && w_ready;
    assign bus.synd_out   = out_q;
    assign bus.synd_idx   = idx_q;
    assign bus.synd_valid = valid_q;
    assign bus.synd_start = start_q;
    assign bus.synd_last  = last_q;
    assign bus.err_free   = ef_q;

endmodule
`default_nettype wire

// File: tb/tb_bch_syndrome_calc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bch_syndrome_calc
//  Description : Self-checking bench for bch_syndrome_calc. Syndromes are
//                predicted as power sums r(alpha^j) from an antilog table.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bch_syndrome_calc;

    localparam int          N         = 8191;
    localparam int          T         = 4;
    localparam logic [13:0] PRIM_POLY = 14'h201B;
    localparam int          NS        = 2 * T;

    logic clk;
    logic reset;

    bch_syndrome_calc_if #(.T(T)) bus ();

    bch_syndrome_calc #(
        .N         (N),
        .T         (T),
        .PRIM_POLY (PRIM_POLY)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          at;
        int          idx;
        logic [12:0] val;
        logic        start;
        logic        last;
        logic        ef;
    } exp_ent_t;

    exp_ent_t    exp_q[$];
    logic [12:0] alpha_pow [0:8191];
    logic        frm [N];
    logic [12:0] model_syn [1:NS];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   edge_cnt = 0;
    int   last_k   = -1000;
    logic exp_ef   = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp_v, edge_cnt);
        end
    endfunction

    // Plain shift-and-add GF(2^13) product, independent of the antilog table
    function automatic logic [12:0] gf_mul(input logic [12:0] a, input logic [12:0] b);
        logic [25:0] p;
        p = '0;
        for (int i = 0; i < 13; i++) begin
            if (b[i]) p = p ^ (26'(a) << i);
        end
        for (int i = 25; i >= 13; i--) begin
            if (p[i]) p = p ^ (26'(PRIM_POLY) << (i - 13));
        end
        return p[12:0];
    endfunction

    // r(alpha^j) evaluated directly as a sum of alpha^(j*d) over set coefficients
    function automatic void compute_model();
        for (int j = 1; j <= NS; j++) begin
            logic [12:0] acc;
            acc = '0;
            for (int d = 0; d < N; d++) begin
                if (frm[d]) acc = acc ^ alpha_pow[(j * d) % 8191];
            end
            model_syn[j] = acc;
        end
    endfunction

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Compare process: outputs after each edge against the expected schedule
    always @(negedge clk) begin
        exp_ent_t e;
        logic     exp_rdy;
        if (reset) begin
            if (exp_q.size() > 0 && exp_q[0].at == edge_cnt) begin
                e = exp_q.pop_front();
                chk("synd_valid", 32'(bus.synd_valid), 32'd1);
                chk("synd_idx",   32'(bus.synd_idx),   32'(e.idx));
                chk("synd_out",   32'(bus.synd_out),   32'(e.val));
                chk("synd_start", 32'(bus.synd_start), 32'(e.start));
                chk("synd_last",  32'(bus.synd_last),  32'(e.last));
                if (e.last) exp_ef = e.ef;
            end else begin
                chk("synd_valid_idle", 32'(bus.synd_valid), 32'd0);
                chk("synd_start_idle", 32'(bus.synd_start), 32'd0);
                chk("synd_last_idle",  32'(bus.synd_last),  32'd0);
            end
            chk("err_free", 32'(bus.err_free), 32'(exp_ef));
            exp_rdy = !(edge_cnt >= last_k && edge_cnt <= last_k + NS - 1);
            chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        end
    end

    task automatic clear_frm();
        for (int d = 0; d < N; d++) frm[d] = 1'b0;
    endtask

    // Present one bit (with optional leading idle cycles); returns 1ns after its edge
    task automatic drive_bit(input logic b, input logic first, input int gap_pct);
        while (int'($urandom_range(99)) < gap_pct) begin
            bus.in_valid = 1'b0;
            bus.in_first = 1'($urandom);
            bus.din      = 1'($urandom);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b1;
        bus.in_first = first;
        bus.din      = b;
        @(posedge clk); #1;
    endtask

    // Send frm highest degree first and schedule the expected dump
    task automatic send_frame(input int gap_pct);
        int   k;
        logic ef;
        for (int i = 0; i < N; i++) drive_bit(frm[N-1-i], (i == 0), gap_pct);
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        k = edge_cnt;
        compute_model();
        ef = 1'b1;
        for (int j = 1; j <= NS; j++) if (model_syn[j] != 0) ef = 1'b0;
        for (int j = 1; j <= NS; j++) begin
            exp_ent_t e;
            e.at = k + j; e.idx = j; e.val = model_syn[j];
            e.start = (j == 1); e.last = (j == NS); e.ef = ef;
            exp_q.push_back(e);
        end
        last_k = k;
    endtask

    task automatic wait_dump();
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        repeat (NS) begin @(posedge clk); #1; end
    endtask

    // Hammer the input with frame starts while the block is dumping
    task automatic dump_inject();
        repeat (NS) begin
            bus.in_valid = 1'b1;
            bus.in_first = 1'b1;
            bus.din      = 1'($urandom);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(bus.synd_valid), 32'd0);
        chk({tag, "_out"},   32'(bus.synd_out),   32'd0);
        chk({tag, "_idx"},   32'(bus.synd_idx),   32'd0);
        chk({tag, "_start"}, 32'(bus.synd_start), 32'd0);
        chk({tag, "_last"},  32'(bus.synd_last),  32'd0);
        chk({tag, "_ef"},    32'(bus.err_free),   32'd0);
        chk({tag, "_ready"}, 32'(bus.in_ready),   32'd0);
    endtask

    initial begin
        logic [13:0] e;
        reset        = 1'b0;
        bus.din      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;

        // Antilog table alpha^i, i = 0..8191
        e = 14'd1;
        for (int i = 0; i <= 8191; i++) begin
            alpha_pow[i] = e[12:0];
            e = e << 1;
            if (e[13]) e = e ^ PRIM_POLY;
        end
        chk("model_alpha13", 32'(alpha_pow[13]), 32'h001B);
        chk("model_alpha8191", 32'(alpha_pow[8191]), 32'h0001);

        // Reset state
        repeat (3) begin @(posedge clk); #1; end
        check_all_zero("reset");
        @(negedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #1;

        // Stray bits in IDLE without a frame start are dropped
        for (int i = 0; i < 5; i++) drive_bit(1'b1, 1'b0, 0);
        bus.in_valid = 1'b0;

        // All-zero frame
        clear_frm();
        send_frame(0);
        wait_dump();

        // Single 1 at degree 0
        clear_frm(); frm[0] = 1'b1;
        send_frame(0);
        for (int j = 1; j <= NS; j++) chk("model_deg0", 32'(model_syn[j]), 32'h0001);
        wait_dump();

        // Single 1 at degree 1
        clear_frm(); frm[1] = 1'b1;
        send_frame(0);
        for (int j = 1; j <= NS; j++) chk("model_deg1", 32'(model_syn[j]), 32'(1 << j));
        wait_dump();

        // Single 1 at degree 13, gapped input, frame starts injected during DUMP
        clear_frm(); frm[13] = 1'b1;
        send_frame(12);
        chk("model_deg13_s1", 32'(model_syn[1]), 32'h001B);
        chk("model_deg13_s2", 32'(model_syn[2]), 32'(gf_mul(13'h001B, 13'h001B)));
        dump_inject();

        // Back-to-back: a 100-bit partial frame, then a restart with degree 1
        for (int i = 0; i < 100; i++) drive_bit(1'($urandom), (i == 0), 0);
        clear_frm(); frm[1] = 1'b1;
        send_frame(0);
        wait_dump();

        // Random frame with light gapping
        for (int d = 0; d < N; d++) frm[d] = 1'($urandom);
        send_frame(5);
        wait_dump();

        // Random frame aborted by reset while synd_idx 3 is showing
        for (int d = 0; d < N; d++) frm[d] = 1'($urandom);
        send_frame(0);
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        exp_q.delete();
        last_k = -1000;
        exp_ef = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", 32'(bus.in_ready), 32'd1);

        // Frame after reset recovery
        for (int d = 0; d < N; d++) frm[d] = 1'($urandom);
        frm[N-1] = 1'b1;
        send_frame(3);
        wait_dump();
        repeat (4) begin @(posedge clk); #1; end

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bch_syndrome_calc.md
Name: bch_syndrome_calc

Overview:
- Serial syndrome generator for the GF(2^13) BCH decoder.
- Accepts the received codeword one bit per accepted cycle, highest-degree coefficient first.
- Evaluates S_j = r(alpha^j) for j = 1..2T using Horner accumulation.
- Streams the 2T 13-bit syndromes, one per cycle, into the decoder's 13-bit load-or-hold feedback registers. Its start strobe drives their load select.

Parameters:
- N, 8191, codeword length in bits (2..8191).
- T, 4, error-correcting capability; 2T syndromes are produced.
- PRIM_POLY, 14'h201B, GF(2^13) field polynomial x^13+x^4+x^3+x+1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- din  input  1  received codeword bit.
- in_valid  input  1  din valid this cycle.
- in_first  input  1  qualifies din as the first (degree N-1) bit of a frame; only meaningful with in_valid.
- in_ready  output  1  block accepts input this cycle.
- synd_out  output  13  current syndrome value.
- synd_idx  output  log2(2T)+1  syndrome index j, 1..2T.
- synd_valid  output  1  synd_out/synd_idx valid.
- synd_start  output  1  high only with j=1; drives downstream register load select.
- synd_last  output  1  high only with j=2T.
- err_free  output  1  all 2T syndromes zero; valid when synd_last=1, held until next frame completes.

Behaviour:
- Reset (asynchronous, active-low):
  - All syndrome accumulators, the bit counter, and every output go to 0.
  - State goes to IDLE.
  - Reset mid-ACCUM or mid-DUMP aborts the frame; no further output is produced.
- Acceptance: a bit is accepted when in_valid && in_ready.
- in_ready: 1 in IDLE and ACCUM, 0 in DUMP. Input during DUMP is ignored, including in_first.
- Field arithmetic:
  - Multiplication by the constant alpha^j is a combinational 13x13 XOR matrix per j, derived from PRIM_POLY.
  - No general multipliers are used.
  - Addition is XOR.
- IDLE:
  - Accepted bits without in_first are discarded.
  - An accepted bit with in_first sets S_j <= {12'b0, din} for all j and cnt <= 1, then goes to ACCUM.
- ACCUM:
  - Each accepted bit: S_j <= (S_j * alpha^j) ^ din for all j in parallel, and cnt <= cnt+1.
  - Cycles with in_valid=0 leave S_j and cnt unchanged.
  - When the accepted bit makes cnt == N, go to DUMP next cycle.
  - An accepted bit with in_first in ACCUM restarts the frame: S_j <= {12'b0, din}, cnt <= 1. The partial frame is discarded.
- DUMP:
  - Lasts exactly 2T consecutive cycles, with synd_valid=1 and synd_idx = 1..2T in order.
  - synd_out = S_idx, driven from registers (registered outputs).
  - synd_start is high on the first DUMP cycle; synd_last is high on the last.
  - err_free is updated on the synd_last cycle as the NOR of all S_j.
  - There is no output backpressure.
  - After the last DUMP cycle: synd_valid=0, return to IDLE, in_ready=1.
- Latency: if the N-th bit is accepted on edge k, synd_valid is high for the cycles following edges k+1 .. k+2T.
- Back-to-back frames: a new in_first is accepted on the first IDLE cycle after DUMP. There are no further dead cycles.
- Width rules:
  - cnt is 13 bits.
  - synd_out is always reduced mod PRIM_POLY, so it is never wider than 13 bits.

Test Plan:
- All-zero frame (N=8191, T=4, in_valid continuous) -> 8 cycles with synd_out=0x0000, idx 1..8, synd_start on idx1, synd_last on idx8, err_free=1.
- Single 1 at degree 0 (last bit) -> all S_j=0x0001, err_free=0.
- Single 1 at degree 1 -> S1..S8 = 0x0002, 0x0004, 0x0008, 0x0010, 0x0020, 0x0040, 0x0080, 0x0100.
- Single 1 at degree 13 -> S1=0x001B; S2=alpha^26 matches a software GF(2^13) model; in_valid randomly gapped gives identical syndromes with DUMP starting 1 cycle after the last accepted bit.
- in_first reasserted after 100 bits, then a full frame with a 1 at degree 1 -> syndromes equal the degree-1 case, with no output from the aborted partial frame; in_first while in DUMP is ignored.
- reset driven low asynchronously at DUMP idx 3 -> all outputs 0 immediately; after release, IDLE with in_ready=1, and the next frame produces correct syndromes.
